// File: rtl/instruction_fetch.sv
// Instruction-fetch front end.
// Owns the fetch PC and issues one word read at a time to instruction memory.
// Each fetched word is handed to decode together with its PC.
// A redirect retargets the PC in any state. If a response is still owed to an
// abandoned request, that response is swallowed through the single drop flag.
module instruction_fetch #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    localparam logic [1:0] REQ  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              drop;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              rsp_take;
    logic              rsp_discard;
    logic              unused_redirect_lsb;

    // Low address bits of a redirect are ignored; targets are always word aligned.
    assign redirect_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // A response in WAIT is either kept or discarded.
    // It is discarded if it belongs to an abandoned request, or if a redirect lands in the same cycle.
    assign rsp_take    = (state == WAIT) && imem_rsp_valid && !drop && !redirect_valid;
    assign rsp_discard = (state == WAIT) && imem_rsp_valid && (drop || redirect_valid);

    // Request is masked during reset so memory never sees a stale request.
    assign imem_req_valid = reset_n && (state == REQ);
    assign imem_req_addr  = fetch_pc;

    // A redirect kills the held instruction in the same cycle, so no transfer can occur.
    assign if_valid = (state == HOLD) && !redirect_valid;

    // Fetch state machine
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= REQ;
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (rsp_take)         state <= HOLD;
                    else if (rsp_discard) state <= REQ;
                end
                HOLD: begin
                    if (redirect_valid || if_ready) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

    // Drop flag: set when the outstanding response must be discarded, cleared when that response arrives.
    // The flag is a single bit because at most one request is ever outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop <= 1'b0;
        end else if (rsp_discard) begin
            drop <= 1'b0;
        end else if (redirect_valid && (((state == REQ) && imem_req_ready) || (state == WAIT))) begin
            drop <= 1'b1;
        end
    end

    // Fetch PC: a redirect has priority; otherwise the PC advances past each kept response (wraps modulo 2^ADDR_W).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
        end else if (rsp_take) begin
            fetch_pc <= req_pc + ADDR_W'(4);
        end
    end

    // Remember the address of the accepted request so the response can be tagged with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_pc <= RESET_PC;
        end else if ((state == REQ) && imem_req_ready) begin
            req_pc <= fetch_pc;
        end
    end

    // Capture instruction and PC for decode; held stable through HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_instr <= '0;
            if_pc    <= '0;
        end else if (rsp_take) begin
            if_instr <= imem_rsp_data;
            if_pc    <= req_pc;
        end
    end

endmodule
